// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data ports, one transaction in flight; grant-to-rvalid is MEM_LAT+2 cycles.
// Backpressure: requests wait (gnt low) until IDLE; data wins ties except after two consecutive data grants.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [3:0]    d_ls,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_ls,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic [1:0] consec_d;
  logic       own_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          if (d_req && (!if_req || consec_d != 2'd2)) d_gnt = 1'b1;
          else if (if_req)                            if_gnt = 1'b1;
        end
        if (d_gnt || if_gnt) state_nxt = ISSUE;
      end
      ISSUE:   state_nxt = (MEM_LAT > 1) ? WAIT : RESP;
      WAIT:    if (cnt == 4'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      consec_d  <= '0;
      own_d     <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_ls    <= '0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      mem_en    <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if (d_gnt || if_gnt) begin
        // the mem_* registers double as the latched command and hold until the next grant
        mem_en    <= 1'b1;
        own_d     <= d_gnt;
        mem_we    <= d_gnt & d_we;
        mem_addr  <= d_gnt ? d_addr  : if_addr;
        mem_wdata <= d_gnt ? d_wdata : '0;
        mem_ls    <= d_gnt ? d_ls    : 4'd0;
      end
      if (d_gnt)  consec_d <= (consec_d == 2'd2) ? 2'd2 : consec_d + 2'd1;
      if (if_gnt) consec_d <= 2'd0;
      case (state)
        ISSUE: cnt <= 4'(MEM_LAT - 1);
        WAIT:  cnt <= cnt - 4'd1;
        RESP: begin
          if (own_d) begin
            d_rdata  <= mem_we ? '0 : mem_rdata;
            d_rvalid <= 1'b1;
          end else begin
            if_rdata  <= mem_rdata;
            if_rvalid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: main build at MEM_LAT=2 plus latency-only builds at 1 and 5.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  d_ls = '0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_ls;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0] ^ 16'hC3C3, ~a[15:0]};
  endfunction

  mem_port_arbiter #(.MEM_LAT(2), .AW(32), .DW(32)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ls(d_ls),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ls(mem_ls),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory: valid data only in the cycle exactly MEM_LAT after mem_en, garbage otherwise.
  int          ncyc = 0;
  int          due = -1;
  logic [31:0] daddr = '0;
  always @(negedge clk) begin
    ncyc++;
    if (mem_en) begin
      due   = ncyc + 2;
      daddr = mem_addr;
    end
    mem_rdata = (ncyc == due) ? mem_val(daddr) : 32'hBAD0BAD0;
  end

  // Latency-variant builds share one fetch stimulus; their memory is a plain lookup of mem_addr.
  logic        lreq = 1'b0, lzero = 1'b0;
  logic [31:0] laddr = '0, lzero32 = '0;
  logic [3:0]  lzero4 = '0;
  logic        g1, rv1, dg1, drv1, me1, mw1, b1, g5, rv5, dg5, drv5, me5, mw5, b5;
  logic [31:0] rd1, drd1, ma1, mwd1, mr1, rd5, drd5, ma5, mwd5, mr5;
  logic [3:0]  ml1, ml5;
  assign mr1 = mem_val(ma1);
  assign mr5 = mem_val(ma5);

  mem_port_arbiter #(.MEM_LAT(1), .AW(32), .DW(32)) u_l1 (
    .clk(clk), .rst(rst),
    .if_req(lreq), .if_addr(laddr), .if_gnt(g1), .if_rvalid(rv1), .if_rdata(rd1),
    .d_req(lzero), .d_we(lzero), .d_addr(lzero32), .d_wdata(lzero32), .d_ls(lzero4),
    .d_gnt(dg1), .d_rvalid(drv1), .d_rdata(drd1),
    .mem_en(me1), .mem_we(mw1), .mem_addr(ma1), .mem_wdata(mwd1), .mem_ls(ml1),
    .mem_rdata(mr1), .busy(b1)
  );

  mem_port_arbiter #(.MEM_LAT(5), .AW(32), .DW(32)) u_l5 (
    .clk(clk), .rst(rst),
    .if_req(lreq), .if_addr(laddr), .if_gnt(g5), .if_rvalid(rv5), .if_rdata(rd5),
    .d_req(lzero), .d_we(lzero), .d_addr(lzero32), .d_wdata(lzero32), .d_ls(lzero4),
    .d_gnt(dg5), .d_rvalid(drv5), .d_rdata(drd5),
    .mem_en(me5), .mem_we(mw5), .mem_addr(ma5), .mem_wdata(mwd5), .mem_ls(ml5),
    .mem_rdata(mr5), .busy(b5)
  );

  task automatic test_reset();
    if_req = 1'b1;
    d_req  = 1'b1;
    @(negedge clk);
    checks++;
    if ({if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_en, mem_we,
         mem_addr, mem_wdata, mem_ls, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b/%b en=%b busy=%b addr=%h exp all zero",
               if_gnt, d_gnt, mem_en, busy, mem_addr);
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_load();
    logic [5:0] o, e;
    for (int c = 0; c < 6; c++) begin
      d_req = (c == 0); d_we = 1'b0; d_addr = 32'h100; d_wdata = '0; d_ls = 4'b0100;
      @(negedge clk);
      o = {d_gnt, if_gnt, mem_en, busy, d_rvalid, if_rvalid};
      e = {c == 0, 1'b0, c == 1, (c >= 1 && c <= 3), c == 4, 1'b0};
      checks++;
      if (o !== e) begin errors++; $display("FAIL load_ctrl c=%0d got %b exp %b", c, o, e); end
      if (c == 1) begin
        checks++;
        if ({mem_we, mem_addr, mem_ls} !== {1'b0, 32'h100, 4'b0100}) begin
          errors++; $display("FAIL load_cmd got we=%b addr=%h ls=%b exp 0/100/0100", mem_we, mem_addr, mem_ls);
        end
      end
      if (c == 4) begin
        checks++;
        if (d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data got %h exp deadbeef", d_rdata); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single_store();
    logic [5:0] o, e;
    for (int c = 0; c < 6; c++) begin
      d_req = (c == 0); d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678; d_ls = 4'b0010;
      @(negedge clk);
      o = {d_gnt, if_gnt, mem_en, busy, d_rvalid, if_rvalid};
      e = {c == 0, 1'b0, c == 1, (c >= 1 && c <= 3), c == 4, 1'b0};
      checks++;
      if (o !== e) begin errors++; $display("FAIL store_ctrl c=%0d got %b exp %b", c, o, e); end
      if (c == 1) begin
        checks++;
        if ({mem_we, mem_addr, mem_wdata, mem_ls} !== {1'b1, 32'h20, 32'h12345678, 4'b0010}) begin
          errors++; $display("FAIL store_cmd got we=%b addr=%h wd=%h ls=%b", mem_we, mem_addr, mem_wdata, mem_ls);
        end
      end
      if (c == 2) begin
        checks++;
        if (d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rdata_hold got %h exp deadbeef", d_rdata); end
      end
      if (c == 4) begin
        checks++;
        if (d_rdata !== 32'h0) begin errors++; $display("FAIL store_ack_data got %h exp 0", d_rdata); end
      end
      @(posedge clk); #1;
    end
    d_we = 1'b0;
  endtask

  task automatic test_fetch_stream();
    logic [5:0] o, e;
    for (int c = 0; c < 14; c++) begin
      if_req  = (c % 4 == 0 && c < 12);
      if_addr = 32'(c);
      d_req   = 1'b0;
      @(negedge clk);
      o = {d_gnt, if_gnt, mem_en, busy, d_rvalid, if_rvalid};
      e = {1'b0, (c % 4 == 0 && c < 12), (c % 4 == 1 && c < 12), (c % 4 != 0 && c < 12),
           1'b0, (c % 4 == 0 && c > 0 && c <= 12)};
      checks++;
      if (o !== e) begin errors++; $display("FAIL fetch_ctrl c=%0d got %b exp %b", c, o, e); end
      if (c % 4 == 0 && c > 0 && c <= 12) begin
        checks++;
        if (if_rdata !== mem_val(32'(c - 4))) begin
          errors++; $display("FAIL fetch_data c=%0d got %h exp %h", c, if_rdata, mem_val(32'(c - 4)));
        end
      end
      if (c == 13) begin
        checks++;
        if (d_rdata !== 32'h0) begin errors++; $display("FAIL fetch_d_idle got %h exp 0", d_rdata); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lat_builds();
    for (int c = 0; c < 10; c++) begin
      lreq  = (c == 0);
      laddr = 32'h40;
      @(negedge clk);
      checks++;
      if ({g1, rv1, g5, rv5} !== {c == 0, c == 3, c == 0, c == 7}) begin
        errors++; $display("FAIL lat_ctrl c=%0d got %b%b%b%b exp %b%b%b%b", c, g1, rv1, g5, rv5,
                           c == 0, c == 3, c == 0, c == 7);
      end
      if (c == 3) begin
        checks++;
        if (rd1 !== 32'hC383FFBF) begin errors++; $display("FAIL lat1_data got %h exp c383ffbf", rd1); end
      end
      if (c == 7) begin
        checks++;
        if (rd5 !== 32'hC383FFBF) begin errors++; $display("FAIL lat5_data got %h exp c383ffbf", rd5); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic        is_d [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] ga   [7] = '{32'h1000, 32'h1004, 32'h2000, 32'h1008, 32'h1010, 32'h200C, 32'h1014};
    logic        gd = 1'b0, gi = 1'b0, eg_d, eg_i, rv_d, rv_i;
    for (int c = 0; c <= 28; c++) begin
      if (gd) d_req = 1'b0;
      if (gi) if_req = 1'b0;
      if (c % 4 == 0 && c < 24) begin
        if (!d_req)  begin d_req = 1'b1;  d_addr  = 32'h1000 + 32'(c); end
        if (!if_req) begin if_req = 1'b1; if_addr = 32'h2000 + 32'(c); end
      end
      @(negedge clk);
      eg_d = 1'b0; eg_i = 1'b0; rv_d = 1'b0; rv_i = 1'b0;
      if (c % 4 == 0 && c <= 24) begin eg_d = is_d[c/4]; eg_i = !is_d[c/4]; end
      if (c % 4 == 0 && c >= 4)  begin rv_d = is_d[c/4-1]; rv_i = !is_d[c/4-1]; end
      checks++;
      if ({d_gnt, if_gnt, d_rvalid, if_rvalid} !== {eg_d, eg_i, rv_d, rv_i}) begin
        errors++; $display("FAIL b2b_ctrl c=%0d got %b%b%b%b exp %b%b%b%b", c,
                           d_gnt, if_gnt, d_rvalid, if_rvalid, eg_d, eg_i, rv_d, rv_i);
      end
      if (rv_d || rv_i) begin
        checks++;
        if ((rv_d ? d_rdata : if_rdata) !== mem_val(ga[c/4-1])) begin
          errors++; $display("FAIL b2b_data c=%0d got %h exp %h", c, rv_d ? d_rdata : if_rdata, mem_val(ga[c/4-1]));
        end
      end
      if (c % 4 == 1) begin
        checks++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, ga[c/4]}) begin
          errors++; $display("FAIL b2b_cmd c=%0d got en=%b we=%b addr=%h exp 1/0/%h", c, mem_en, mem_we, mem_addr, ga[c/4]);
        end
      end
      gd = d_gnt; gi = if_gnt;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic        is_d [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] ga   [4] = '{32'h1100, 32'h1104, 32'h2100, 32'h1108};
    logic        gd = 1'b0, gi = 1'b0, eg_d, eg_i, rv_d, rv_i;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    @(negedge clk);
    @(posedge clk); #1;
    d_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, mem_addr} !== {1'b1, 32'h300}) begin
      errors++; $display("FAIL mid_wait got busy=%b addr=%h exp 1/300", busy, mem_addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_en, mem_we,
         mem_addr, mem_wdata, mem_ls, busy} !== '0) begin
      errors++; $display("FAIL mid_reset_async got busy=%b addr=%h rdata=%h/%h exp all zero",
                         busy, mem_addr, if_rdata, d_rdata);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({d_rvalid, busy, mem_en} !== 3'b000) begin
        errors++; $display("FAIL mid_reset_hold i=%0d got %b%b%b exp 000", i, d_rvalid, busy, mem_en);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      if (gd) d_req = 1'b0;
      if (gi) if_req = 1'b0;
      if (c % 4 == 0 && c < 12 && !d_req) begin d_req = 1'b1; d_addr = 32'h1100 + 32'(c); end
      if (c == 0) begin if_req = 1'b1; if_addr = 32'h2100; end
      @(negedge clk);
      eg_d = 1'b0; eg_i = 1'b0; rv_d = 1'b0; rv_i = 1'b0;
      if (c % 4 == 0 && c <= 12) begin eg_d = is_d[c/4]; eg_i = !is_d[c/4]; end
      if (c % 4 == 0 && c >= 4)  begin rv_d = is_d[c/4-1]; rv_i = !is_d[c/4-1]; end
      checks++;
      if ({d_gnt, if_gnt, d_rvalid, if_rvalid} !== {eg_d, eg_i, rv_d, rv_i}) begin
        errors++; $display("FAIL post_reset_ctrl c=%0d got %b%b%b%b exp %b%b%b%b", c,
                           d_gnt, if_gnt, d_rvalid, if_rvalid, eg_d, eg_i, rv_d, rv_i);
      end
      if (rv_d || rv_i) begin
        checks++;
        if ((rv_d ? d_rdata : if_rdata) !== mem_val(ga[c/4-1])) begin
          errors++; $display("FAIL post_reset_data c=%0d got %h exp %h", c, rv_d ? d_rdata : if_rdata, mem_val(ga[c/4-1]));
        end
      end
      gd = d_gnt; gi = if_gnt;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_load();
    test_single_store();
    test_fetch_stream();
    test_lat_builds();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sequences and shares one single-ported unified memory between the pipeline's instruction-fetch port and its load/store (data) port. One transaction is outstanding at a time. The arbiter grants one requester, drives the memory command for one cycle, waits a fixed memory latency, then returns read data or a write acknowledgement to the owner. Data accesses have priority, with an anti-starvation rule that guarantees fetch progress.

Parameters:
MEM_LAT, 2, cycles from the mem_en cycle to the cycle mem_rdata is valid (legal range 1..15).
AW, 32, address width.
DW, 32, data width.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
if_req  in  1  fetch request
if_addr  in  AW  fetch address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  fetch data valid, 1-cycle pulse
if_rdata  out  DW  fetch data
d_req  in  1  data request
d_we  in  1  1 = store, 0 = load
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_ls  in  4  load/store width/sign type, passed through unchanged
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  load data / store ack, 1-cycle pulse
d_rdata  out  DW  load data; 0 for store acks
mem_en  out  1  memory command strobe, 1-cycle pulse
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_ls  out  4  memory access type
mem_rdata  in  DW  memory read data
busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Reset:
  - rst=1 forces all of the following immediately and asynchronously: state IDLE, wait counter 0, fairness counter consec_d 0.
  - All registered outputs go to 0: mem_en, mem_we, mem_addr, mem_wdata, mem_ls, if_rvalid, d_rvalid, if_rdata, d_rdata.
  - if_gnt, d_gnt and busy are forced to 0 while rst=1.
  - A transaction in flight when reset asserts is dropped; its late mem_rdata is ignored.
- State machine, states IDLE / ISSUE / WAIT / RESP:
  - IDLE: arbitration is combinational; gnt asserts in the same cycle as req. If any gnt=1, latch the owner, we, addr, wdata and ls, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE, cycle T: mem_en=1 and mem_* carry the latched command. Load the wait counter with MEM_LAT-1; go to WAIT if MEM_LAT>1, otherwise go to RESP.
  - WAIT: decrement the counter; when it reaches 0, go to RESP. mem_en=0 throughout.
  - RESP, cycle T+MEM_LAT: register mem_rdata (or 0 for a store) into the owner's rdata. At cycle T+MEM_LAT+1, pulse the owner's rvalid for one cycle; the state is IDLE in that same cycle, so a new grant may coincide with the rvalid pulse.
- Throughput: one transaction every MEM_LAT+2 cycles back-to-back. Grant-to-rvalid latency is MEM_LAT+2 cycles.
- Arbitration, evaluated only in IDLE; gnt=0 in all other states:
  - Only one requester asserting req: that requester is granted.
  - Both asserting and consec_d<2: data port wins.
  - Both asserting and consec_d==2: fetch port wins.
  - consec_d update: each data grant increments it, saturating at 2; each fetch grant clears it to 0.
  - At most one gnt is high in any cycle.
- Handshake rules:
  - A requester holds req and all its fields stable until it sees gnt. It may drop or change them in the cycle after gnt.
  - A requester must not re-request before its rvalid; a violation causes undefined behaviour. The bench must not generate it.
- rdata holds its value after the rvalid pulse until the same port's next response. The idle requester's rdata and rvalid are not disturbed.
- mem_addr, mem_wdata, mem_ls and mem_we hold their latched values after ISSUE until the next ISSUE.
- A req that rises during ISSUE, WAIT or RESP is not granted until the cycle the state returns to IDLE.

Test Plan:
- Single load, MEM_LAT=2:
  - Stimulus: d_req=1, d_we=0, d_addr=0x100 at cycle 0; memory returns 0xDEADBEEF at cycle 3.
  - Required: d_gnt@0, mem_en@1 with mem_addr=0x100, d_rvalid@4 with d_rdata=0xDEADBEEF, busy high for cycles 1-3.
- Single store:
  - Stimulus: d_we=1, d_addr=0x20, d_wdata=0x12345678, d_ls=4'b0010.
  - Required: mem_en=mem_we=1 for one cycle with matching fields; d_rvalid pulse with d_rdata=0; if_rvalid stays 0.
- Simultaneous requests:
  - Stimulus: if_req and d_req held continuously.
  - Required: grant order D, D, IF, D, D, IF. Consecutive grants are MEM_LAT+2 cycles apart, and each rvalid goes to the correct port.
- Fetch-only stream:
  - Stimulus: if_req held for addresses 0x0, 0x4, 0x8.
  - Required: if_gnt every 4 cycles; if_rvalid returns the data in order; d_* outputs idle.
- MEM_LAT=1 and MEM_LAT=5 builds:
  - Stimulus: a single fetch on each build.
  - Required: rvalid exactly 3 and 7 cycles after gnt respectively.
- Reset mid-operation:
  - Stimulus: assert rst during WAIT of a load.
  - Required: all outputs 0 immediately, no rvalid for the dropped load. After rst deasserts, a new d_req is granted in the first IDLE cycle, with consec_d cleared (if both req, data wins twice before fetch).
